// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer
//   Drives an external combinational matrix multiply-accumulate core across a
//   job of k_tiles K-tiles: D = sum_t A_t * B_t (+ C0). A and B tiles arrive
//   over a joint valid/ready handshake. The running accumulator is fed back to
//   the core as C. The final M x N result is presented on d_data until d_ready.
//
//   Optional feature macro: MATMUL_SEQ_BIAS_EN
//     When defined, the c_valid/c_ready/c_data ports are added. A LOAD_C state
//     follows every accepted start and preloads the accumulator with C0.
//     When undefined, the accumulator starts at zero.
//
// Ports
//   clk, rst                   clock, async active-high reset
//   start, k_tiles, busy       job launch, tile count (captured on start), job active
//   a_valid/a_ready/a_data     A tile stream, element [i][j] at (i*K+j)*P
//   b_valid/b_ready/b_data     B tile stream, element [i][j] at (i*N+j)*P
//   core_a/core_b/core_c       registered tiles and accumulator to the core
//   core_d                     core result (A*B + C), sign-extended, wrapping
//   d_valid/d_ready/d_data     result, element [i][j] at (i*N+j)*4P
//   c_valid/c_ready/c_data     bias preload (MATMUL_SEQ_BIAS_EN only)
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_C | waiting for the bias matrix to preload the accumulator
// FETCH  | waiting for A and B tiles valid together
// ACC    | core sees the registered tiles; accumulator takes core_d
// OUT    | result held on d_data until d_ready

module matmul_tile_sequencer #(
  parameter int M    = 8,
  parameter int N    = 4,
  parameter int K    = 16,
  parameter int P    = 8,
  parameter int KT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KT_W-1:0]      k_tiles,
  output logic                 busy,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [M*K*P-1:0]     a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [K*N*P-1:0]     b_data,
  output logic [M*K*P-1:0]     core_a,
  output logic [K*N*P-1:0]     core_b,
  output logic [M*N*4*P-1:0]   core_c,
  input  logic [M*N*4*P-1:0]   core_d,
  output logic                 d_valid,
  input  logic                 d_ready,
`ifdef MATMUL_SEQ_BIAS_EN
  input  logic                 c_valid,
  output logic                 c_ready,
  input  logic [M*N*4*P-1:0]   c_data,
`endif
  output logic [M*N*4*P-1:0]   d_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_C = 3'd1,
    S_FETCH  = 3'd2,
    S_ACC    = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t               state;
  logic [M*K*P-1:0]     a_reg;
  logic [K*N*P-1:0]     b_reg;
  logic [M*N*4*P-1:0]   acc;
  logic [KT_W-1:0]      tile_cnt;
  logic [KT_W-1:0]      tile_total;
  logic                 tile_hs;
  logic [KT_W-1:0]      tile_cnt_nxt;

  // Both tiles are taken on the same edge or not at all, so one stream can
  // never run ahead of the other.
  assign tile_hs      = (state == S_FETCH) && a_valid && b_valid;
  assign tile_cnt_nxt = tile_cnt + KT_W'(1);

  assign a_ready = tile_hs;
  assign b_ready = tile_hs;
  assign d_valid = (state == S_OUT);
  assign d_data  = acc;
  assign core_a  = a_reg;
  assign core_b  = b_reg;
  assign core_c  = acc;

`ifdef MATMUL_SEQ_BIAS_EN
  assign c_ready = (state == S_LOAD_C) && c_valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      tile_cnt   <= '0;
      tile_total <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            tile_total <= k_tiles;
            tile_cnt   <= '0;
            acc        <= '0;
`ifdef MATMUL_SEQ_BIAS_EN
            state      <= S_LOAD_C;
`else
            state      <= (k_tiles == '0) ? S_OUT : S_FETCH;
`endif
          end
        end
`ifdef MATMUL_SEQ_BIAS_EN
        S_LOAD_C: begin
          if (c_valid) begin
            acc   <= c_data;
            state <= (tile_total == '0) ? S_OUT : S_FETCH;
          end
        end
`endif
        S_FETCH: begin
          if (tile_hs) begin
            a_reg <= a_data;
            b_reg <= b_data;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          acc      <= core_d;
          tile_cnt <= tile_cnt_nxt;
          state    <= (tile_cnt_nxt == tile_total) ? S_OUT : S_FETCH;
        end
        S_OUT: begin
          if (d_ready) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Testbench for matmul_tile_sequencer. It provides a behavioural model of the
// combinational MAC core. Expected results are pushed into a scoreboard queue
// when each job starts. A negedge monitor pops an entry and compares it against
// d_data on every result handshake.
module tb_matmul_tile_sequencer;

  localparam int M    = 8;
  localparam int N    = 4;
  localparam int K    = 16;
  localparam int P    = 8;
  localparam int KT_W = 8;
  localparam int AW   = 4 * P;
  localparam int AWID = M * K * P;
  localparam int BWID = K * N * P;
  localparam int CWID = M * N * AW;
`ifdef MATMUL_SEQ_BIAS_EN
  localparam int LC = 1;
`else
  localparam int LC = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KT_W-1:0] k_tiles;
  logic            busy;
  logic            a_valid, a_ready;
  logic [AWID-1:0] a_data;
  logic            b_valid, b_ready;
  logic [BWID-1:0] b_data;
  logic [AWID-1:0] core_a;
  logic [BWID-1:0] core_b;
  logic [CWID-1:0] core_c;
  logic [CWID-1:0] core_d;
  logic            d_valid, d_ready;
  logic [CWID-1:0] d_data;
`ifdef MATMUL_SEQ_BIAS_EN
  logic            c_valid, c_ready;
  logic [CWID-1:0] c_data;
`endif

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  matmul_tile_sequencer #(.M(M), .N(N), .K(K), .P(P), .KT_W(KT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_tiles(k_tiles), .busy(busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
    .d_valid(d_valid), .d_ready(d_ready),
`ifdef MATMUL_SEQ_BIAS_EN
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
`endif
    .d_data(d_data)
  );

  // Behavioural MAC core: D = A*B + C, products sign-extended, wrapping sum.
  function automatic logic [CWID-1:0] core_model(input logic [AWID-1:0] a,
                                                 input logic [BWID-1:0] b,
                                                 input logic [CWID-1:0] c);
    logic [CWID-1:0]      r;
    logic signed [AW-1:0] s, pa, pb;
    r = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        s = c[(i*N+j)*AW +: AW];
        for (int k = 0; k < K; k++) begin
          pa = AW'($signed(a[(i*K+k)*P +: P]));
          pb = AW'($signed(b[(k*N+j)*P +: P]));
          s  = s + pa * pb;
        end
        r[(i*N+j)*AW +: AW] = s;
      end
    end
    return r;
  endfunction

  always_comb core_d = core_model(core_a, core_b, core_c);

  function automatic logic all_eq(input logic [CWID-1:0] d, input logic [AW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int e = 0; e < M*N; e++)
      if (d[e*AW +: AW] !== v) ok = 1'b0;
    return ok;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Launch a job; returns with the FSM past any bias preload.
  task automatic do_start(input logic [KT_W-1:0] kt, input logic [AW-1:0] expv);
    exp_q.push_back(expv);
    k_tiles = kt;
    start   = 1'b1;
    step();
    start   = 1'b0;
    repeat (LC) step();
  endtask

  always @(posedge clk)
    if (!rst && a_valid && a_ready) hs_cnt++;

  // Scoreboard monitor, plus the rule that a stalled result must not change.
  logic            hold_prev = 1'b0;
  logic [CWID-1:0] data_prev;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      check("ready_pair", a_ready, b_ready);
      if (hold_prev) begin
        check("stall_valid", d_valid, 1'b1);
        checks++;
        if (d_data !== data_prev) begin
          errors++;
          $display("FAIL stall_data: d_data changed during stall (elem0 got %0d, held %0d)",
                   $signed(d_data[AW-1:0]), $signed(data_prev[AW-1:0]));
        end
      end
      if (d_valid && d_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: result elem0 %0d with empty scoreboard",
                   $signed(d_data[AW-1:0]));
        end else begin
          logic [AW-1:0] ev;
          ev = exp_q.pop_front();
          if (!all_eq(d_data, ev)) begin
            errors++;
            $display("FAIL sb_result: elem0 got %0d, last got %0d, expected all %0d",
                     $signed(d_data[AW-1:0]), $signed(d_data[CWID-1 -: AW]), $signed(ev));
          end
        end
      end
      hold_prev = d_valid && !d_ready;
      data_prev = d_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs0;
    logic [P-1:0]  v8;
    logic [AW-1:0] v32;
    rst = 1'b1; start = 1'b0; k_tiles = '0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; d_ready = 1'b1;
`ifdef MATMUL_SEQ_BIAS_EN
    c_valid = 1'b1; c_data = '0;
`endif
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_core_a", core_a == '0, 1);
    check("rst_core_c", core_c == '0, 1);
    rst = 1'b0;
    step();

    // k_tiles=1, A=B=1, pre-valid: handshake at cycle 1, d_valid at cycle 3.
    v8 = 8'd1;
    a_data = {M*K{v8}}; b_data = {K*N{v8}};
    a_valid = 1'b1; b_valid = 1'b1;
    check("t2_idle_no_ready", a_ready, 0);
    do_start(8'd1, 32'd16);
    check("t2_busy", busy, 1);
    check("t2_fetch_ready", a_ready, 1);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check("t2_acc_no_valid", d_valid, 0);
    step();
    check("t2_out_valid", d_valid, 1);
    step();
    check("t2_idle_busy", busy, 0);

    // k_tiles=3, A=2, B=3, b_valid trailing a_valid by two cycles.
    v8 = 8'd2; a_data = {M*K{v8}};
    v8 = 8'd3; b_data = {K*N{v8}};
    hs0 = hs_cnt;
    do_start(8'd3, 32'd288);
    for (int t = 0; t < 3; t++) begin
      a_valid = 1'b1;
      #1;
      check("t3_a_only_a", a_ready, 0);
      check("t3_a_only_b", b_ready, 0);
      step();
      check("t3_a_only_a2", a_ready, 0);
      step();
      b_valid = 1'b1;
      #1;
      check("t3_both_ready", a_ready, 1);
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      step();
    end
    check("t3_out_valid", d_valid, 1);
    check("t3_handshakes", hs_cnt - hs0, 3);
    step();

    // k_tiles=0: d_valid one cycle after start, no tile handshake.
    hs0 = hs_cnt;
    a_valid = 1'b1; b_valid = 1'b1;
    do_start(8'd0, 32'd0);
    check("t4_out_valid", d_valid, 1);
    check("t4_no_ready", a_ready, 0);
    step();
    check("t4_no_handshake", hs_cnt - hs0, 0);
    a_valid = 1'b0; b_valid = 1'b0;

    // Result stall with start pulsed while busy.
    d_ready = 1'b0;
    v8 = 8'd1;
    a_data = {M*K{v8}}; b_data = {K*N{v8}};
    a_valid = 1'b1; b_valid = 1'b1;
    do_start(8'd1, 32'd16);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t5_stall_valid", d_valid, 1);
      check("t5_stall_busy", busy, 1);
      check("t5_stall_data", all_eq(d_data, 32'd16), 1);
      if (i == 2) start = 1'b1;
      step();
      start = 1'b0;
    end
    d_ready = 1'b1;
    step();
    check("t5_release_busy", busy, 0);
    check("t5_release_valid", d_valid, 0);
    step();
    check("t5_start_ignored", busy, 0);

    // Reset during the second of three tiles, then a clean job.
    a_valid = 1'b1; b_valid = 1'b1;
    do_start(8'd3, 32'd0);
    void'(exp_q.pop_back());
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("t1_rst_busy", busy, 0);
    check("t1_rst_a_ready", a_ready, 0);
    step();
    check("t1_busy", busy, 0);
    check("t1_d_valid", d_valid, 0);
    check("t1_a_ready", a_ready, 0);
    rst = 1'b0;
    step();
    do_start(8'd1, 32'd16);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    check("t1_new_valid", d_valid, 1);
    step();

`ifdef MATMUL_SEQ_BIAS_EN
    // Bias preload: C0=-100, A=-128, B=127, one tile.
    v32 = -32'sd100; c_data = {M*N{v32}};
    v8 = 8'h80; a_data = {M*K{v8}};
    v8 = 8'h7f; b_data = {K*N{v8}};
    a_valid = 1'b1; b_valid = 1'b1;
    do_start(8'd1, -32'sd260196);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    check("t6_out_valid", d_valid, 1);
    step();
    c_data = '0;
`else
    v32 = '0;
`endif

    step();
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
